muldiv_sequencer: RTL and testbench

Iterative sequencer for the RV32M multiply/divide instructions, sitting beside the main ALU in the execute stage. It accepts one operation per handshake and computes it over multiple cycles: one product bit or quotient bit per cycle. While it runs it holds `busy` so the hazard logic can stall the pipeline. Divide-by-zero and signed-overflow cases are resolved immediately, as the ISA requires.

---
 rtl/muldiv_pkg.sv | 50 +++++
 rtl/muldiv_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types and operation predicates for the RV32M sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return (op inside {OP_REM, OP_REMU});
    endfunction

    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op inside {OP_MULH, OP_DIV, OP_REM});
    endfunction

    function automatic logic wants_high(input muldiv_op_e op);
        return (op inside {OP_MULH, OP_MULHSU, OP_MULHU});
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative RV32M multiply/divide unit, one result bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int                 c_CNT_W   = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e      r_state;
    muldiv_state_e      w_state_next;
    muldiv_op_e         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    muldiv_op_e         w_op;
    logic               w_accept;
    logic               w_div_zero;
    logic               w_overflow;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_result;
    logic               w_in_sign_a;
    logic               w_in_sign_b;
    logic [WIDTH-1:0]   w_in_mag_a;
    logic [WIDTH-1:0]   w_in_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH+1:0]   w_div_shift;
    logic [WIDTH+1:0]   w_div_sub;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_result;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    // ---------------- request decode ----------------
    assign w_op       = muldiv_op_e'(funct3);
    assign w_accept   = (r_state == S_IDLE) && start && !flush;
    assign w_div_zero = is_div(w_op) && (operand_b == '0);
    assign w_overflow = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                        (operand_a == c_MIN_NEG) && (operand_b == '1);
    assign w_special  = w_div_zero || w_overflow;

    always_comb begin
        w_special_result = '0;
        if (w_div_zero)
            w_special_result = is_rem(w_op) ? operand_a : '1;
        else if (w_overflow)
            w_special_result = is_rem(w_op) ? '0 : c_MIN_NEG;
    end

    assign w_in_sign_a = is_signed_a(w_op) && operand_a[WIDTH-1];
    assign w_in_sign_b = is_signed_b(w_op) && operand_b[WIDTH-1];
    assign w_in_mag_a  = w_in_sign_a ? (-operand_a) : operand_a;
    assign w_in_mag_b  = w_in_sign_b ? (-operand_b) : operand_b;

    // ---------------- iteration step ----------------
    // Multiply: high half accumulates, whole accumulator shifts right so the
    // next multiplier bit lands in bit 0.
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                         {1'b0, (r_acc[0] ? r_mag_a : {WIDTH{1'b0}})};
    // Divide: shift next dividend bit into the partial remainder and trial-subtract.
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_sub   = w_div_shift - {2'b00, r_mag_b};

    // ---------------- sign correction and selection ----------------
    assign w_prod = (r_sign_a ^ r_sign_b) ? (-r_acc) : r_acc;
    assign w_quo  = (r_sign_a ^ r_sign_b) ? (-r_quo) : r_quo;
    assign w_rem  = r_sign_a ? (-r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

    always_comb begin
        w_fix_result = w_prod[WIDTH-1:0];
        if (is_div(r_op))
            w_fix_result = is_rem(r_op) ? w_rem : w_quo;
        else if (wants_high(r_op))
            w_fix_result = w_prod[2*WIDTH-1:WIDTH];
    end

    // ---------------- FSM ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = w_special ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == c_LAST) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush)
            w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (w_state_next == S_DONE);
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_op;
                        r_sign_a <= w_in_sign_a;
                        r_sign_b <= w_in_sign_b;
                        r_mag_a  <= w_in_mag_a;
                        r_mag_b  <= w_in_mag_b;
                        r_cnt    <= '0;
                        r_acc    <= {{WIDTH{1'b0}}, w_in_mag_b};
                        r_rem    <= '0;
                        r_quo    <= w_in_mag_a;
                        if (w_special)
                            r_result <= w_special_result;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (is_div(r_op)) begin
                        r_rem <= w_div_sub[WIDTH+1] ? w_div_shift[WIDTH:0] : w_div_sub[WIDTH:0];
                        r_quo <= {r_quo[WIDTH-2:0], ~w_div_sub[WIDTH+1]};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (!flush)
                        r_result <= w_fix_result;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Directed, table-driven checks of the RV32M multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts one operation in the next cycle (cycle 0) and follows it to done.
    // poke >= 1 drives a stray start in that cycle of the running operation.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input int poke);
        int  cyc;
        bit  seen;
        bit  busy_ok;
        @(negedge clk);
        check({name, "_idle_before"}, {30'd0, busy, done}, 32'd0);
        start = 1'b1; funct3 = op; operand_a = a; operand_b = b;
        @(negedge clk);
        cyc = 1; seen = 1'b0; busy_ok = 1'b1;
        start = 1'b0;
        while (!seen && cyc <= 60) begin
            if (cyc == poke) begin
                start = 1'b1; funct3 = 3'b100; operand_a = 32'd100; operand_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done in cycle %0d", name, lat);
        end else begin
            check({name, "_latency"}, cyc, lat);
            check({name, "_result"}, result, exp);
            check({name, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        end
    endtask

    initial begin
        int n_done;

        vecs[0]  = '{"mul_7_m3",       3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{"mulh_min_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        vecs[2]  = '{"mulhu_max_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{"mulhsu_m1_2",    3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{"div_m7_2",       3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
        vecs[5]  = '{"rem_m7_2",       3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
        vecs[6]  = '{"divu_m7_2",      3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34};
        vecs[7]  = '{"remu_m7_2",      3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 34};
        vecs[8]  = '{"divu_5_0",       3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{"rem_5_0",        3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
        vecs[10] = '{"div_ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{"rem_ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[12] = '{"div_100_m7",     3'b100, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34};
        vecs[13] = '{"rem_100_m7",     3'b110, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 34};
        vecs[14] = '{"mul_low",        3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34};
        vecs[15] = '{"mulh_m7_2",      3'b001, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};

        rst_n = 1'b0; start = 1'b0; funct3 = 3'b000;
        operand_a = '0; operand_b = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, -1);

        // Stray start in cycle 5 of a running MUL must not disturb it.
        run_op("mul_poke", 3'b000, 32'd6, 32'd7, 32'd42, 34, 5);

        // Start and flush together in IDLE: flush wins.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; operand_a = 32'd2; operand_b = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush_busy", {31'd0, busy}, 32'd0);

        // Flush a DIV in cycle 10.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; operand_a = 32'd100; operand_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_c10", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_c11", {31'd0, busy}, 32'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("flush_no_done", n_done, 0);
        check("flush_result_kept", result, 32'd42);

        // Asynchronous reset in cycle 20 of a MUL.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; operand_a = 32'h0000_FFFF; operand_b = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_busy",   {31'd0, busy}, 32'd0);
        check("async_reset_done",   {31'd0, done}, 32'd0);
        check("async_reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("reset_no_done", n_done, 0);

        run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 34, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
